// File: rtl/fir_pkg.sv
// Shared constants and sample types for the FIR post-processing chain.
package fir_pkg;

    localparam int FIR_DATA_W_IN  = 32;
    localparam int FIR_DATA_W_OUT = 16;

    // Saturation limits for the default output width.
    localparam int OUT_MAX = (1 << (FIR_DATA_W_OUT - 1)) - 1;
    localparam int OUT_MIN = -(1 << (FIR_DATA_W_OUT - 1));

    typedef logic signed [FIR_DATA_W_IN-1:0]  sample_in_t;
    typedef logic signed [FIR_DATA_W_OUT-1:0] sample_out_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO. A write while full is accepted only when a
// pop happens in the same cycle; otherwise the caller sees it dropped.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_requant_decim.sv
// Decimate the FIR output stream, round-shift and saturate kept samples,
// and buffer them for a valid/ready consumer.
// Optional macro FIR_REQUANT_STATS_EN adds a 16-bit saturation counter port.
module fir_requant_decim
    import fir_pkg::*;
#(
    parameter int DATA_W_IN  = FIR_DATA_W_IN,
    parameter int DATA_W_OUT = FIR_DATA_W_OUT,
    parameter int SHIFT      = 6,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W_IN-1:0]  in_data,
    input  logic                  in_valid,
    output logic [DATA_W_OUT-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
`ifdef FIR_REQUANT_STATS_EN
    output logic [15:0]           sat_count,
`endif
    input  logic                  clr_ovf
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0] PH_ONE  = 1;

    // Half-LSB rounding constant; zero when no shift is applied.
    localparam logic signed [DATA_W_IN:0] RND =
        (SHIFT > 0) ? (DATA_W_IN + 1)'(1 << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [DATA_W_IN:0] SAT_HI =
        {{(DATA_W_IN - DATA_W_OUT + 2){1'b0}}, {(DATA_W_OUT - 1){1'b1}}};
    localparam logic signed [DATA_W_IN:0] SAT_LO =
        {{(DATA_W_IN - DATA_W_OUT + 2){1'b1}}, {(DATA_W_OUT - 1){1'b0}}};

    logic [PH_W-1:0]              phase;
    logic                         keep;
    logic signed [DATA_W_IN:0]    in_ext;
    logic signed [DATA_W_IN:0]    sum_rnd;
    logic signed [DATA_W_IN:0]    rounded;
    logic signed [DATA_W_IN:0]    r1;
    logic                         v1;
    logic                         clip_hi;
    logic                         clip_lo;
    logic [DATA_W_OUT-1:0]        sat_val;
    logic [DATA_W_OUT-1:0]        r2;
    logic                         v2;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [DATA_W_OUT-1:0]        fifo_rd;
    logic                         pop;
    logic                         drop;
    logic [DATA_W_OUT-1:0]        hold;

    assign keep = in_valid && (phase == '0);

    // Phase counter advances on valid input only and wraps at DECIM-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
        end
    end

    // Round half-up then arithmetic shift, one bit wider so the add cannot wrap.
    always_comb begin
        in_ext  = {in_data[DATA_W_IN-1], in_data};
        sum_rnd = in_ext + RND;
        rounded = sum_rnd >>> SHIFT;
    end

    // Clamp the rounded value to the signed output range.
    always_comb begin
        clip_hi = (r1 > SAT_HI);
        clip_lo = (r1 < SAT_LO);
        if (clip_hi) begin
            sat_val = SAT_HI[DATA_W_OUT-1:0];
        end else if (clip_lo) begin
            sat_val = SAT_LO[DATA_W_OUT-1:0];
        end else begin
            sat_val = r1[DATA_W_OUT-1:0];
        end
    end

    // Two-stage pipeline: round/shift, then saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r1 <= '0;
            v1 <= 1'b0;
            r2 <= '0;
            v2 <= 1'b0;
        end else begin
            v1 <= keep;
            if (keep) r1 <= rounded;
            v2 <= v1;
            if (v1) r2 <= sat_val;
        end
    end

    assign pop  = out_ready && !fifo_empty;
    assign drop = v2 && fifo_full && !pop;

    fir_sync_fifo #(
        .WIDTH (DATA_W_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (v2),
        .wr_data (r2),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty)
    );

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Remember the last popped value so out_data is stable while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= '0;
        end else if (pop) begin
            hold <= fifo_rd;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? hold : fifo_rd;

`ifdef FIR_REQUANT_STATS_EN
    // Count clipped samples in either direction, sticking at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (clr_ovf) begin
            sat_count <= '0;
        end else if (v1 && (clip_hi || clip_lo) && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_requant_decim.sv
// Directed bench: one DUT with DECIM=1 and one with DECIM=4 share the inputs.
module tb_fir_requant_decim;

    logic               clk;
    logic               reset;
    logic [31:0]        in_data;
    logic               in_valid;
    logic               out_ready;
    logic               clr_ovf;
    logic signed [15:0] od1, od4;
    logic               ov1, ov4;
    logic               of1, of4;
`ifdef FIR_REQUANT_STATS_EN
    logic [15:0]        sc1, sc4;
`endif

    int total;
    int bad;
    int q1[$];
    int q4[$];
    logic mon_en;
    logic v0, v1;

    typedef struct {
        logic [31:0] din;
        int          want;
    } vec_t;
    vec_t vecs[10];

    fir_requant_decim #(.SHIFT(6), .DECIM(1), .FIFO_DEPTH(4)) u_d1 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (od1),
        .out_valid (ov1),
        .out_ready (out_ready),
        .overflow  (of1),
`ifdef FIR_REQUANT_STATS_EN
        .sat_count (sc1),
`endif
        .clr_ovf   (clr_ovf)
    );

    fir_requant_decim #(.SHIFT(6), .DECIM(4), .FIFO_DEPTH(4)) u_d4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (od4),
        .out_valid (ov4),
        .out_ready (out_ready),
        .overflow  (of4),
`ifdef FIR_REQUANT_STATS_EN
        .sat_count (sc4),
`endif
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every pop that the next rising edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ov1 && out_ready) q1.push_back(int'(od1));
            if (ov4 && out_ready) q4.push_back(int'(od4));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
    endtask

    initial begin
        total = 0; bad = 0; mon_en = 1'b0;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_ovf = 1'b0;

        vecs[0] = '{32'd100, 2};
        vecs[1] = '{32'(-96), -1};
        vecs[2] = '{32'd32, 1};
        vecs[3] = '{32'd31, 0};
        vecs[4] = '{32'(-32), 0};
        vecs[5] = '{32'(-33), -1};
        vecs[6] = '{32'd2097087, 32767};
        vecs[7] = '{32'(-2097152), -32768};
        vecs[8] = '{32'h7FFF_FFFF, 32767};
        vecs[9] = '{32'h8000_0000, -32768};

        // Reset state.
        repeat (2) tick;
        chk("rst_valid1", 32'(ov1), 0);
        chk("rst_data1", 32'(od1), 0);
        chk("rst_ovf1", 32'(of1), 0);
        chk("rst_valid4", 32'(ov4), 0);
        chk("rst_ovf4", 32'(of4), 0);
        reset = 1'b1;
        tick;

        // Rounding and saturation vectors, with latency and hold checks.
        for (int i = 0; i < 10; i++) begin
            in_data = vecs[i].din; in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            v0 = ov1;
            tick;
            v1 = ov1;
            tick;
            chk($sformatf("lat%0d", i), 32'({v0, v1, ov1}), 3'b001);
            chk($sformatf("data%0d", i), od1, vecs[i].want);
            tick;
            chk($sformatf("hold%0d", i), od1, vecs[i].want);
        end
`ifdef FIR_REQUANT_STATS_EN
        chk("sat_count", 32'(sc1), 2);
`endif

        // Decimation with gapped valid: DECIM=4 keeps n=0,4,8.
        pulse_reset;
        q1.delete(); q4.delete(); mon_en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            in_data = 32'(n * 64); in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            tick;
        end
        repeat (6) tick;
        mon_en = 1'b0;
        chk("decim_count", q4.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("decim%0d", i), (i < q4.size()) ? q4[i] : -999, i * 4);
        chk("decim1_count", q1.size(), 12);

        // Sustained throughput at DECIM=1 with out_ready held.
        pulse_reset;
        q1.delete(); mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'((i - 2) * 64); in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        repeat (6) tick;
        mon_en = 1'b0;
        chk("thru_count", q1.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("thru%0d", i), (i < q1.size()) ? q1[i] : -999, i - 2);
        chk("thru_ovf", 32'(of1), 0);

        // Backpressure: four retained, fifth dropped.
        pulse_reset;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_data = 32'(i * 64); in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        repeat (3) tick;
        chk("bp_ovf", 32'(of1), 1);
        chk("bp_valid", 32'(ov1), 1);
        chk("bp_head", od1, 1);
        q1.delete(); mon_en = 1'b1; out_ready = 1'b1;
        repeat (6) tick;
        mon_en = 1'b0;
        chk("bp_count", q1.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp%0d", i), (i < q1.size()) ? q1[i] : -999, i + 1);
        chk("bp_empty", 32'(ov1), 0);
        chk("bp_sticky", 32'(of1), 1);
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(of1), 0);

        // Drop coinciding with clr_ovf: set wins, buffered head unchanged.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'((10 + i) * 64); in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        tick;
        chk("full_no_ovf", 32'(of1), 0);
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        chk("set_wins", 32'(of1), 1);
        chk("full_head", od1, 10);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("pop_head", od1, 11);

        // Asynchronous reset with three entries buffered.
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(ov1), 0);
        chk("arst_ovf", 32'(of1), 0);
        chk("arst_data", od1, 0);
        chk("arst_valid4", 32'(ov4), 0);
        tick;
        reset = 1'b1;
        out_ready = 1'b1;
        in_data = 32'(7 * 64); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("post_rst_valid1", 32'(ov1), 1);
        chk("post_rst_data1", od1, 7);
        chk("post_rst_valid4", 32'(ov4), 1);
        chk("post_rst_data4", od4, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_requant_decim.md
Name: fir_requant_decim

Overview:
- Downstream stage for the pipelined 9-tap FIR.
- Takes the FIR's 32-bit signed output stream and keeps one sample in every DECIM valid samples.
- Rounds and shifts each kept sample, then saturates it to 16 bits signed.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the next consumer (DAC or packetiser).

Parameters:
- DATA_W_IN, 32, input sample width (signed).
- DATA_W_OUT, 16, output sample width (signed).
- SHIFT, 6, arithmetic right shift applied after rounding; 0 to 24 legal.
- DECIM, 4, decimation ratio; 1 to 256 legal; 1 means keep every sample.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- in_data, input, DATA_W_IN, signed sample from the FIR data_out.
- in_valid, input, 1, in_data qualifies this cycle; no backpressure to the FIR.
- out_data, output, DATA_W_OUT, signed requantised sample at the FIFO head.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, consumer accepts out_data this cycle.
- overflow, output, 1, sticky: a kept sample was dropped because the FIFO was full.
- clr_ovf, input, 1, synchronous clear of overflow.

Behaviour:
- Reset (one clock, async, active-low):
  - Asserted while reset=0.
  - Clears phase counter, pipeline valids, FIFO pointers and overflow.
  - out_valid=0, out_data=0, overflow=0.
  - Reset mid-operation discards all buffered and in-flight samples immediately.
- Decimation:
  - phase counter 0..DECIM-1 advances only on in_valid=1.
  - Wraps DECIM-1 to 0.
  - A sample with in_valid=1 and phase==0 is kept; all others are discarded.
  - The first valid sample after reset is kept.
- Stage 1 (capture edge k):
  - r1 <= (in_data + 2^(SHIFT-1)) >>> SHIFT.
  - Computed in DATA_W_IN+1 bits so the rounding add cannot wrap.
  - With SHIFT=0 there is no add.
  - Rounding is round-half-up (toward +inf).
- Stage 2 (edge k+1):
  - r2 <= saturate(r1) to [-2^(DATA_W_OUT-1), 2^(DATA_W_OUT-1)-1].
  - Saturated values are -32768 and 32767 at the defaults.
- FIFO write (edge k+2):
  - r2 is written to the FIFO if it is not full.
  - out_valid rises after edge k+2 when the FIFO was empty.
  - Latency from capture to out_valid is 3 edges.
- Output:
  - FIFO is show-ahead: out_data equals the head entry whenever out_valid=1.
  - A pop occurs on out_valid and out_ready.
  - out_data holds its last value when the FIFO is empty (0 after reset).
- Full/overflow:
  - A write while full with no simultaneous pop drops the new sample.
  - The dropped sample sets overflow=1; buffered entries are unchanged.
  - A write while full with a same-cycle pop succeeds, and occupancy stays full.
  - If clr_ovf and a drop occur in the same cycle, overflow stays 1 (set wins).
- Empty: out_ready with out_valid=0 has no effect.
- Pointers wrap modulo FIFO_DEPTH; a count register of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Throughput: one kept sample per cycle sustained (DECIM=1, out_ready=1) with no drops.

Optional Feature:
- Macro FIR_REQUANT_STATS_EN.
- When defined:
  - Adds output port sat_count, 16 bits.
  - sat_count increments whenever stage 2 clips a value in either direction.
  - It saturates at 0xFFFF and is cleared by reset and by clr_ovf.
- When undefined:
  - The port and counter are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package fir_pkg holds:
  - FIR_DATA_W_IN=32 and FIR_DATA_W_OUT=16.
  - Derived constants OUT_MAX and OUT_MIN.
  - Typedefs sample_in_t (signed [31:0]) and sample_out_t (signed [15:0]).
- Sub-module fir_sync_fifo:
  - Parameterised width and depth; show-ahead.
  - Ports wr_en, wr_data, full, rd_en, rd_data, empty.
  - Instantiated once.
- Rounding, saturation and decimation logic stay in the top module.

Test Plan:
- Rounding, positive (DECIM=1, SHIFT=6, out_ready=1): in_data=100 -> out_data=2, out_valid 3 edges after capture.
- Rounding, negative: in_data=-96 -> -1; in_data=32 -> 1; in_data=31 -> 0.
- Saturation:
  - in_data=0x7FFFFFFF -> 32767.
  - in_data=0x80000000 -> -32768.
  - With FIR_REQUANT_STATS_EN defined, sat_count=2.
- Decimation (DECIM=4, SHIFT=6): feed n*64 for n=0..11 with in_valid gapped every other cycle -> outputs 0, 4, 8 only.
- Backpressure (out_ready=0, DECIM=1, FIFO_DEPTH=4):
  - Send 5 samples; entries 1..4 are retained and the 5th is dropped, overflow=1.
  - Raise out_ready -> 4 outputs in order.
  - Pulse clr_ovf -> overflow=0.
- Reset mid-stream: drop reset to 0 while the FIFO holds 3 entries -> out_valid=0 and overflow=0 immediately (asynchronous); the next valid sample after release is kept (phase 0).
